mem_stage_ctrl: RTL

Memory-stage controller for the 8-bit pipelined CPU. It consumes the control/data bundle held in the EXE/MEM pipeline register and, for loads and stores, runs a req/ack handshake with the data RAM. It stalls upstream stages while an access is outstanding and produces the MEM/WB register bundle consumed by write-back.

---
 rtl/mem_stage_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs the data-RAM req/ack handshake for loads and
// stores, stalls upstream while busy and drives the MEM/WB register bundle.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        WB_in,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] alu_RAM_address,
  input  logic [DATA_W-1:0] RAM_data,
  input  logic [3:0]        mux1_in,
  output logic              stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic [1:0]        WB_O,
  output logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] alu_result_O,
  output logic [3:0]        mux1_O,
  output logic              mem_err
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_rq_t;

  typedef struct packed {
    logic [1:0]        wb;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] alu;
    logic [3:0]        mux;
  } mem_wb_t;

  state_t          state, state_d;
  ram_rq_t         rq_q, rq_d;
  mem_wb_t         wb_q, wb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            to_hit;

  // cnt_q counts ACCESS edges already passed without ack
  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state;
    rq_d    = rq_q;
    wb_d    = wb_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state)
      IDLE: begin
        if (read | write) begin
          rq_d.req   = 1'b1;
          rq_d.we    = write;
          rq_d.addr  = alu_RAM_address;
          rq_d.wdata = RAM_data;
          wb_d.wb    = 2'b00;
          cnt_d      = '0;
          state_d    = ACCESS;
        end else begin
          wb_d.wb    = WB_in;
          wb_d.rdata = '0;
          wb_d.alu   = alu_RAM_address;
          wb_d.mux   = mux1_in;
        end
      end
      ACCESS: begin
        if (ram_ack) begin
          rq_d.req   = 1'b0;
          wb_d.wb    = WB_in;
          wb_d.rdata = rq_q.we ? '0 : ram_rdata;
          wb_d.alu   = rq_q.addr;
          wb_d.mux   = mux1_in;
          state_d    = DONE;
        end else if (to_hit) begin
          rq_d.req   = 1'b0;
          err_d      = 1'b1;
          wb_d.wb    = 2'b00;
          wb_d.rdata = '0;
          state_d    = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        wb_d.wb = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // pipeline registers update on the falling edge
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rq_q  <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      rq_q  <= rq_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign stall         = rst_n & (((state == IDLE) & (read | write)) | (state == ACCESS));
  assign ram_req       = rq_q.req;
  assign ram_we        = rq_q.we;
  assign ram_addr      = rq_q.addr;
  assign ram_wdata     = rq_q.wdata;
  assign WB_O          = wb_q.wb;
  assign mem_read_data = wb_q.rdata;
  assign alu_result_O  = wb_q.alu;
  assign mux1_O        = wb_q.mux;
  assign mem_err       = err_q;

endmodule
